// File: rtl/dircc_nios_debug_jtag_pkg.sv
// Shared types and constants for the on-chip Nios II debug virtual-JTAG host.
package dircc_nios_debug_jtag_pkg;

  localparam int unsigned DEBUG_SR_W = 38;
  localparam int unsigned VJI_IR_W   = 2;

  localparam logic [VJI_IR_W-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [VJI_IR_W-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [VJI_IR_W-1:0] IR_BREAK     = 2'd2;
  localparam logic [VJI_IR_W-1:0] IR_TRACECTRL = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    UIR   = 3'd1,
    CDR   = 3'd2,
    SHIFT = 3'd3,
    UDR   = 3'd4,
    RTI   = 3'd5,
    RESP  = 3'd6
  } state_t;

endpackage

// File: rtl/dircc_nios_debug_jtag_tck_gen.sv
// Test-clock divider: tck is low for the first TCK_DIV clk of each period, high for the second.
module dircc_nios_debug_jtag_tck_gen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tck,
  output logic tck_rise_c,
  output logic tck_fall_c
);

  localparam int unsigned DIV_W = $clog2(TCK_DIV) + 1;
  localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(TCK_DIV - 1);
  localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(2 * TCK_DIV - 1);

  logic [DIV_W-1:0] div_q;

  // Strobes flag the clk edge on which tck is about to change.
  assign tck_rise_c = enable && !clear && (div_q == RISE_AT);
  assign tck_fall_c = enable && !clear && (div_q == FALL_AT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      tck   <= 1'b0;
    end else if (clear) begin
      div_q <= '0;
      tck   <= 1'b0;
    end else if (enable) begin
      if (tck_fall_c) begin
        div_q <= '0;
        tck   <= 1'b0;
      end else begin
        div_q <= div_q + DIV_W'(1);
        if (tck_rise_c) tck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dircc_nios_debug_jtag_host.sv
// Virtual-JTAG initiator: turns one {ir, data} command into a UIR/CDR/SDR/UDR/RTI scan
// against the Nios II debug slave and returns the captured shift data.
module dircc_nios_debug_jtag_host
  import dircc_nios_debug_jtag_pkg::*;
#(
  parameter int unsigned DATA_W   = DEBUG_SR_W,
  parameter int unsigned IR_W     = VJI_IR_W,
  parameter int unsigned TCK_DIV  = 4,
  parameter int unsigned RTI_TCKS = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IR_W-1:0]   cmd_ir,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [IR_W-1:0]   rsp_ir_out,
  output logic              vji_tck,
  output logic              vji_tdi,
  input  logic              vji_tdo,
  output logic [IR_W-1:0]   vji_ir_in,
  input  logic [IR_W-1:0]   vji_ir_out,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic              vji_rti
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned RTI_W = (RTI_TCKS > 1) ? $clog2(RTI_TCKS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [RTI_W-1:0] LAST_RTI = RTI_W'((RTI_TCKS > 0) ? (RTI_TCKS - 1) : 0);

  state_t            state_q, state_nxt;
  logic [DATA_W-1:0] sr_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [RTI_W-1:0]  rti_cnt_q;
  logic              tck_rise_c, tck_fall_c, tck_hold_c;

  // tck parks low outside a scan; leaving IDLE starts from a cleared divider.
  assign tck_hold_c = (state_q == IDLE) || (state_q == RESP);

  dircc_nios_debug_jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (tck_hold_c),
    .enable     (!tck_hold_c),
    .tck        (vji_tck),
    .tck_rise_c (tck_rise_c),
    .tck_fall_c (tck_fall_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:  if (cmd_valid) state_nxt = UIR;
      UIR:   if (tck_fall_c) state_nxt = CDR;
      CDR:   if (tck_fall_c) state_nxt = SHIFT;
      SHIFT: if (tck_fall_c && (bit_cnt_q == LAST_BIT)) state_nxt = UDR;
      UDR:   if (tck_fall_c) state_nxt = (RTI_TCKS == 0) ? RESP : RTI;
      RTI:   if (tck_fall_c && (rti_cnt_q == LAST_RTI)) state_nxt = RESP;
      RESP:  if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and handshakes are registered copies of the next state so they span whole states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ir_out <= '0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b1;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      rti_cnt_q  <= '0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      vji_uir   <= (state_nxt == UIR);
      vji_cdr   <= (state_nxt == CDR);
      vji_sdr   <= (state_nxt == SHIFT);
      vji_udr   <= (state_nxt == UDR);
      vji_rti   <= (state_nxt == IDLE) || (state_nxt == RTI) || (state_nxt == RESP);
      if ((state_nxt == RESP) && (state_q != RESP)) rsp_data <= sr_q;

      case (state_q)
        IDLE: if (cmd_valid) begin
          sr_q      <= cmd_data;
          vji_ir_in <= cmd_ir;
          vji_tdi   <= 1'b0;
          bit_cnt_q <= '0;
          rti_cnt_q <= '0;
        end
        UIR: if (tck_rise_c) rsp_ir_out <= vji_ir_out;
        CDR: if (tck_fall_c) vji_tdi <= sr_q[0];
        SHIFT: begin
          if (tck_rise_c) sr_q <= {vji_tdo, sr_q[DATA_W-1:1]};
          if (tck_fall_c) begin
            if (bit_cnt_q == LAST_BIT) begin
              vji_tdi <= 1'b0;
            end else begin
              vji_tdi   <= sr_q[0];
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end
        end
        RTI: if (tck_fall_c) rti_cnt_q <= rti_cnt_q + RTI_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dircc_nios_debug_jtag_host.sv
// Directed/randomized bench for the virtual-JTAG host: default-timing instance with a
// capture/shift slave model, plus a TCK_DIV=1, RTI_TCKS=0 instance looped tdi->tdo.
module tb_dircc_nios_debug_jtag_host;
  import dircc_nios_debug_jtag_pkg::*;

  localparam int unsigned DW  = 38;
  localparam int unsigned DIV = 4;
  localparam int unsigned RTN = 2;
  localparam int LAT   = (3 + DW + RTN) * 2 * DIV;
  localparam int F_LAT = (3 + DW) * 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready;
  logic [1:0]    cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [DW-1:0] cmd_data, rsp_data;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  dircc_nios_debug_jtag_host dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_tdo(vji_tdo),
    .vji_ir_in(vji_ir_in), .vji_ir_out(vji_ir_out),
    .vji_uir(vji_uir), .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_rti(vji_rti)
  );

  // Fast instance
  logic          f_cmd_valid, f_cmd_ready, f_rsp_valid, f_rsp_ready;
  logic [1:0]    f_cmd_ir, f_rsp_ir_out, f_vji_ir_in, f_vji_ir_out;
  logic [DW-1:0] f_cmd_data, f_rsp_data;
  logic          f_vji_tck, f_vji_tdi;
  logic          f_vji_uir, f_vji_cdr, f_vji_sdr, f_vji_udr, f_vji_rti;

  dircc_nios_debug_jtag_host #(.TCK_DIV(1), .RTI_TCKS(0)) dut_fast (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(f_cmd_valid), .cmd_ready(f_cmd_ready), .cmd_ir(f_cmd_ir), .cmd_data(f_cmd_data),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_data(f_rsp_data), .rsp_ir_out(f_rsp_ir_out),
    .vji_tck(f_vji_tck), .vji_tdi(f_vji_tdi), .vji_tdo(f_vji_tdi),
    .vji_ir_in(f_vji_ir_in), .vji_ir_out(f_vji_ir_out),
    .vji_uir(f_vji_uir), .vji_cdr(f_vji_cdr), .vji_sdr(f_vji_sdr), .vji_udr(f_vji_udr), .vji_rti(f_vji_rti)
  );

  // Slave model: loads slv_cap in CDR, shifts tdi in / tdo out during SDR, logs every tdi bit.
  logic [DW-1:0] slv_sr, slv_cap;
  logic          slv_tie1;
  logic [1:0]    slv_ir_out;
  bit            tdi_log [0:4095];
  int            tdi_cnt;

  assign vji_tdo    = slv_tie1 ? 1'b1 : slv_sr[0];
  assign vji_ir_out = slv_ir_out;

  always @(posedge vji_tck) begin
    if (vji_cdr) slv_sr <= slv_cap;
    else if (vji_sdr) begin
      slv_sr <= {vji_tdi, slv_sr[DW-1:1]};
      tdi_log[tdi_cnt] <= vji_tdi;
      tdi_cnt <= tdi_cnt + 1;
    end
  end

  // Running strobe-width and tck-toggle counters, sampled mid-cycle.
  int   c_uir, c_cdr, c_sdr, c_udr;
  int   fc_uir, fc_cdr, fc_sdr, fc_udr, f_tog;
  logic f_prev_tck;
  always @(negedge clk) begin
    if (vji_uir) c_uir <= c_uir + 1;
    if (vji_cdr) c_cdr <= c_cdr + 1;
    if (vji_sdr) c_sdr <= c_sdr + 1;
    if (vji_udr) c_udr <= c_udr + 1;
    if (f_vji_uir) fc_uir <= fc_uir + 1;
    if (f_vji_cdr) fc_cdr <= fc_cdr + 1;
    if (f_vji_sdr) fc_sdr <= fc_sdr + 1;
    if (f_vji_udr) fc_udr <= fc_udr + 1;
    if (f_vji_sdr && (f_vji_tck !== f_prev_tck)) f_tog <= f_tog + 1;
    f_prev_tck <= f_vji_tck;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return DW'({$urandom(), $urandom()});
  endfunction

  // One full scan on the default instance; poke_at >= 0 injects a foreign command mid-scan.
  task automatic run_main(input logic [1:0] ir, input logic [DW-1:0] data, input logic [DW-1:0] cap,
                          input logic [1:0] iro, input bit tie1, input int poke_at, input int hold);
    int n, s_uir, s_cdr, s_sdr, s_udr, s_tdi;
    logic [DW-1:0] want_rsp, seen_tdi;
    slv_cap = cap; slv_ir_out = iro; slv_tie1 = tie1;
    s_uir = c_uir; s_cdr = c_cdr; s_sdr = c_sdr; s_udr = c_udr; s_tdi = tdi_cnt;
    want_rsp = tie1 ? '1 : cap;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_ir = ir; cmd_data = data; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("ir_in", vji_ir_in, ir);
    check("busy_ready", cmd_ready, 0);
    n = 0;
    while (!rsp_valid && n < 2 * LAT) begin
      if (n == poke_at) begin
        cmd_valid = 1'b1; cmd_ir = ~ir; cmd_data = ~data;
      end
      tick();
      n++;
      cmd_valid = 1'b0;
    end
    check("latency", n, LAT);
    check("rsp_data", rsp_data, want_rsp);
    check("rsp_ir_out", rsp_ir_out, iro);
    seen_tdi = '0;
    for (int i = 0; i < int'(DW); i++) seen_tdi[i] = tdi_log[s_tdi + i];
    check("tdi_bits", tdi_cnt - s_tdi, DW);
    check("tdi_seq", seen_tdi, data);
    check("uir_width", c_uir - s_uir, 2 * DIV);
    check("cdr_width", c_cdr - s_cdr, 2 * DIV);
    check("sdr_width", c_sdr - s_sdr, DW * 2 * DIV);
    check("udr_width", c_udr - s_udr, 2 * DIV);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("resp_hold", {rsp_valid, cmd_ready, vji_tck, rsp_data}, {1'b1, 1'b0, 1'b0, want_rsp});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("after_handshake", {rsp_valid, cmd_ready, vji_rti, vji_tck}, 4'b0110);
    if (poke_at >= 0) begin
      s_uir = c_uir;
      repeat (20) tick();
      check("no_second_scan", {c_uir - s_uir, 7'(0), cmd_ready, vji_tck}, {32'd0, 7'(0), 1'b1, 1'b0});
    end
  endtask

  initial begin
    int n, s_tdi, s_udr, fs_uir, fs_cdr, fs_sdr, fs_udr, fs_tog;
    logic [DW-1:0] fd;
    logic [1:0]    fir, firo;

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_ir = '0; cmd_data = '0; rsp_ready = 1'b0;
    f_cmd_valid = 1'b0; f_cmd_ir = '0; f_cmd_data = '0; f_rsp_ready = 1'b0; f_vji_ir_out = '0;
    slv_tie1 = 1'b0; slv_cap = '0; slv_ir_out = '0;
    repeat (3) tick();
    check("reset_ctrl", {vji_rti, cmd_ready, rsp_valid, vji_tck, vji_tdi}, 5'b11000);
    check("reset_strobes", {vji_uir, vji_cdr, vji_sdr, vji_udr}, 4'b0000);
    check("reset_data", {rsp_data, vji_ir_in, rsp_ir_out}, '0);
    reset_n = 1'b1;
    tick();

    run_main(IR_OCIMEM, 38'h2A_5555_AAAA, rand_data(), 2'b01, 1'b0, -1, 0);
    run_main(IR_BREAK, rand_data(), rand_data(), 2'b10, 1'b1, -1, 50);
    run_main(IR_TRACEMEM, rand_data(), rand_data(), 2'b11, 1'b0, 100, 0);
    for (int k = 0; k < 3; k++)
      run_main(2'($urandom()), rand_data(), rand_data(), 2'($urandom()), 1'b0, -1, int'($urandom_range(0, 5)));

    // Fast instance: tdo looped from tdi, so the response must equal the command data.
    for (int k = 0; k < 2; k++) begin
      fd = rand_data(); fir = 2'($urandom()); firo = 2'($urandom());
      f_vji_ir_out = firo;
      fs_uir = fc_uir; fs_cdr = fc_cdr; fs_sdr = fc_sdr; fs_udr = fc_udr; fs_tog = f_tog;
      f_cmd_data = fd; f_cmd_ir = fir; f_cmd_valid = 1'b1;
      tick();
      f_cmd_valid = 1'b0;
      n = 0;
      while (!f_rsp_valid && n < 4 * F_LAT) begin
        tick();
        n++;
      end
      check("fast_latency", n, F_LAT);
      check("fast_rsp_data", f_rsp_data, fd);
      check("fast_ir", {f_rsp_ir_out, f_vji_ir_in}, {firo, fir});
      check("fast_widths", {8'(fc_uir - fs_uir), 8'(fc_cdr - fs_cdr), 8'(fc_sdr - fs_sdr), 8'(fc_udr - fs_udr)},
            {8'd2, 8'd2, 8'(DW * 2), 8'd2});
      check("fast_tck_toggles", f_tog - fs_tog, DW * 2);
      f_rsp_ready = 1'b1;
      tick();
      f_rsp_ready = 1'b0;
      check("fast_handshake", {f_rsp_valid, f_cmd_ready, f_vji_rti, f_vji_tck}, 4'b0110);
    end

    // Reset in the middle of SHIFT must abandon the scan without a UDR pulse.
    slv_tie1 = 1'b0; slv_cap = rand_data();
    s_tdi = tdi_cnt; s_udr = c_udr;
    cmd_data = rand_data(); cmd_ir = IR_TRACECTRL; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while ((tdi_cnt - s_tdi) < 20 && n < 2 * LAT) begin
      tick();
      n++;
    end
    check("reach_bit20", tdi_cnt - s_tdi, 20);
    reset_n = 1'b0;
    #1;
    check("midscan_reset", {vji_sdr, vji_tck, vji_rti, cmd_ready, rsp_valid}, 5'b00110);
    check("midscan_reset_data", {vji_uir, vji_cdr, vji_udr, vji_tdi, vji_ir_in, rsp_data}, '0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (400) tick();
    check("no_udr_after_reset", c_udr - s_udr, 0);
    check("idle_after_reset", {rsp_valid, cmd_ready, vji_rti, vji_tck}, 4'b0110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
